// File: rtl/isa_dma_dac_pkg.sv
// Shared register map, bit positions and reset constants for the ISA DMA playback DAC.
package isa_dma_dac_pkg;

  localparam logic [2:0] REG_DATA    = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_RATE_LO = 3'd2;
  localparam logic [2:0] REG_RATE_HI = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;

  localparam int unsigned CTRL_DMA_EN = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_PLAY   = 2;

  localparam int unsigned ST_EMPTY    = 0;
  localparam int unsigned ST_FULL     = 1;
  localparam int unsigned ST_TC       = 2;
  localparam int unsigned ST_UNDERRUN = 3;

  localparam logic [7:0]  SAMPLE_RESET = 8'h80;
  localparam logic [15:0] RATE_RESET   = 16'hFFFF;

endpackage

// File: rtl/isa_dma_dac_if.sv
// XT bus-side signal bundle between the chipset arbiter (master) and the DAC (slave).
interface isa_dma_dac_if;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        io_read_n;
  logic        io_write_n;
  logic        address_enable_n;
  logic        dma_acknowledge_n;
  logic        terminal_count_n;
  logic        dma_request;
  logic        interrupt_request;
  logic [7:0]  data_bus_out;
  logic        data_bus_out_valid;

  modport slave (
    input  address, internal_data_bus, io_read_n, io_write_n,
           address_enable_n, dma_acknowledge_n, terminal_count_n,
    output dma_request, interrupt_request, data_bus_out, data_bus_out_valid
  );

  modport master (
    output address, internal_data_bus, io_read_n, io_write_n,
           address_enable_n, dma_acknowledge_n, terminal_count_n,
    input  dma_request, interrupt_request, data_bus_out, data_bus_out_valid
  );
endinterface

// File: rtl/dac_fifo.sv
// Synchronous byte FIFO with occupancy count; pushes when full and pops when empty are ignored.
module dac_fifo #(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wr_data,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/isa_dma_dac.sv
// DMA-fed 8-bit playback DAC on the XT bus: register file, rate timer and FIFO drain.
// Optional IRQ support is built when PCXT_DAC_IRQ_EN is defined.
module isa_dma_dac
  import isa_dma_dac_pkg::*;
#(
  parameter logic [15:0] BASE_PORT  = 16'h0300,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  isa_dma_dac_if.slave     bus,
  output logic [7:0]       sample_out
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

`ifdef PCXT_DAC_IRQ_EN
  localparam logic [2:0] CTRL_MASK = 3'b111;
`else
  localparam logic [2:0] CTRL_MASK = 3'b101;
`endif

  logic          wr_prev;
  logic          wr_fall;
  logic          cpu_sel;
  logic          cpu_wr;
  logic          dma_wr;
  logic          push;
  logic          pop_evt;
  logic [2:0]    offset;
  logic [7:0]    wdata;
  logic [2:0]    ctrl;
  logic [15:0]   rate;
  logic [15:0]   rate_cnt;
  logic          tc_flag;
  logic          underrun;
  logic [7:0]    read_val;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^bus.address[19:16];

  assign wr_fall = wr_prev & ~bus.io_write_n;
  assign cpu_sel = ~bus.address_enable_n & bus.dma_acknowledge_n &
                   (bus.address[15:3] == BASE_PORT[15:3]);
  assign offset  = bus.address[2:0];
  assign wdata   = bus.internal_data_bus;
  assign cpu_wr  = cpu_sel & wr_fall;
  assign dma_wr  = ~bus.dma_acknowledge_n & wr_fall;
  assign push    = dma_wr | (cpu_wr & (offset == REG_DATA));
  assign pop_evt = ctrl[CTRL_PLAY] & (rate_cnt == '0);

  dac_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop_evt),
    .wr_data (wdata),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev    <= 1'b1;
      ctrl       <= '0;
      rate       <= RATE_RESET;
      rate_cnt   <= RATE_RESET;
      tc_flag    <= 1'b0;
      underrun   <= 1'b0;
      sample_out <= SAMPLE_RESET;
    end else begin
      wr_prev <= bus.io_write_n;
      if (cpu_wr) begin
        case (offset)
          REG_CTRL:    ctrl       <= wdata[2:0] & CTRL_MASK;
          REG_RATE_LO: rate[7:0]  <= wdata;
          REG_RATE_HI: rate[15:8] <= wdata;
          REG_STATUS: begin
            if (wdata[ST_TC])       tc_flag  <= 1'b0;
            if (wdata[ST_UNDERRUN]) underrun <= 1'b0;
          end
          default: ;
        endcase
      end
      if (dma_wr && !bus.terminal_count_n) begin
        tc_flag           <= 1'b1;
        ctrl[CTRL_DMA_EN] <= 1'b0;
      end
      // RATE_HI reload uses the freshly written high byte with the current low byte.
      if (cpu_wr && offset == REG_RATE_HI)
        rate_cnt <= {wdata, rate[7:0]};
      else if (!ctrl[CTRL_PLAY] || rate_cnt == '0)
        rate_cnt <= rate;
      else
        rate_cnt <= rate_cnt - 1'b1;
      // Underrun set is placed after the STATUS clear so a coincident set wins.
      if (pop_evt) begin
        if (fifo_empty) underrun   <= 1'b1;
        else            sample_out <= fifo_head;
      end
    end
  end

  always_comb begin
    read_val = '0;
    case (offset)
      REG_DATA:    read_val = 8'(fifo_count);
      REG_CTRL:    read_val = {5'b0, ctrl};
      REG_RATE_LO: read_val = rate[7:0];
      REG_RATE_HI: read_val = rate[15:8];
      REG_STATUS:  read_val = {4'b0, underrun, tc_flag, fifo_full, fifo_empty};
      default:     read_val = '0;
    endcase
  end

  assign bus.data_bus_out_valid = cpu_sel & ~bus.io_read_n;
  assign bus.data_bus_out       = bus.data_bus_out_valid ? read_val : '0;
  assign bus.dma_request        = ctrl[CTRL_DMA_EN] & (fifo_count <= CW'(FIFO_DEPTH - 2));

`ifdef PCXT_DAC_IRQ_EN
  assign bus.interrupt_request = ctrl[CTRL_IRQ_EN] & (tc_flag | underrun);
`else
  assign bus.interrupt_request = 1'b0;
`endif

endmodule
